// File: rtl/cga_isa_wbuf_pkg.sv
// Shared types for the ISA posted-write buffer: the queued-entry layout and the
// state encodings of the write and read FSMs.
package cga_isa_wbuf_pkg;

  localparam int VRAM_AW = 19;

  // Entry address width is fixed at VRAM_AW; the top-level AW must match it.
  typedef struct packed {
    logic [VRAM_AW-1:0] addr;
    logic [7:0]         data;
  } wbuf_entry_t;

  typedef enum logic [1:0] {W_IDLE, W_PEND, W_DONE} wr_state_t;

  typedef enum logic [1:0] {R_IDLE, R_SLOT, R_LAT, R_DONE} rd_state_t;

endpackage

// File: rtl/cga_isa_wbuf_if.sv
// VRAM arbiter port as seen from the ISA write buffer: the buffer drives
// addr/data/strobes (master), the arbiter returns read data (slave).
interface cga_isa_wbuf_if #(
  parameter int AW = 19
);
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_din;
  logic          vram_write;
  logic          vram_read;
  logic [7:0]    vram_dout;

  modport master (
    output vram_addr, vram_din, vram_write, vram_read,
    input  vram_dout
  );

  modport slave (
    input  vram_addr, vram_din, vram_write, vram_read,
    output vram_dout
  );
endinterface

// File: rtl/cga_isa_wbuf_fifo.sv
// Posted-write FIFO: register storage, wrap-bit pointers, occupancy, head entry and
// an address CAM that reports the newest matching entry for read forwarding.
module cga_isa_wbuf_fifo
  import cga_isa_wbuf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               push_i,
  input  wbuf_entry_t        push_entry_i,
  input  logic               pop_i,
  input  logic [VRAM_AW-1:0] cmp_addr_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [LW-1:0]      level_o,
  output wbuf_entry_t        head_o,
  output logic               hit_o,
  output logic [7:0]         hit_data_o
);
  localparam int IW = $clog2(DEPTH);

  wbuf_entry_t   mem_q [DEPTH];
  logic [LW-1:0] wptr_q, rptr_q;
  logic [IW-1:0] slot_idx [DEPTH];
  logic [DEPTH-1:0] match;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + LW'(1);
      if (pop_i)  rptr_q <= rptr_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[IW-1:0]] <= push_entry_i;
  end

  assign level_o = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[IW] != rptr_q[IW]) && (wptr_q[IW-1:0] == rptr_q[IW-1:0]);
  assign head_o  = mem_q[rptr_q[IW-1:0]];

  // Match vector is indexed by age offset from the head, so the highest set bit is newest.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cam
    assign slot_idx[gi] = rptr_q[IW-1:0] + IW'(gi);
    assign match[gi]    = (LW'(gi) < level_o) && (mem_q[slot_idx[gi]].addr == cmp_addr_i);
  end

  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = 8'h00;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) begin
        hit_o      = 1'b1;
        hit_data_o = mem_q[slot_idx[k]].data;
      end
    end
  end

endmodule

// File: rtl/cga_isa_wbuf.sv
// ISA posted-write buffer: edge detect on the synced strobes, write and read FSMs,
// sequencer-slot arbitration between read misses and FIFO drain, output registers.
module cga_isa_wbuf
  import cga_isa_wbuf_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int AW     = VRAM_AW,
  parameter  int RD_LAT = 2,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic [AW-1:0] isa_addr,
  input  logic [7:0]    isa_din,
  input  logic          isa_write,
  input  logic          isa_read,
  input  logic          isa_op_enable,
  output logic [7:0]    isa_dout,
  output logic          bus_rdy,
  output logic [LW-1:0] fifo_level,
  output logic          overflow,
  cga_isa_wbuf_if.master vram
);
  localparam int CW = $clog2(RD_LAT) + 1;

  wr_state_t   w_state_q, w_state_d;
  rd_state_t   r_state_q, r_state_d;
  logic        wr_prev_q, rd_prev_q, rd_defer_q;
  logic [7:0]  dout_q, dout_d;
  logic        ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        wr_edge, rd_req, push, pop, space, read_slot;
  logic        full, empty, hit;
  logic [7:0]  hit_data;
  wbuf_entry_t head;

  cga_isa_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_l        (rst_l),
    .push_i       (push),
    .push_entry_i ('{addr: isa_addr, data: isa_din}),
    .pop_i        (pop),
    .cmp_addr_i   (isa_addr),
    .full_o       (full),
    .empty_o      (empty),
    .level_o      (fifo_level),
    .head_o       (head),
    .hit_o        (hit),
    .hit_data_o   (hit_data)
  );

  assign wr_edge   = isa_write & ~wr_prev_q;
  // A read edge that collides with a write edge is replayed one cycle later.
  assign rd_req    = isa_read & (~rd_prev_q | rd_defer_q);
  assign read_slot = (r_state_q == R_SLOT) && isa_read && isa_op_enable;
  assign pop       = isa_op_enable && !empty && !((r_state_q == R_SLOT) && isa_read);
  assign space     = !full || pop;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      wr_prev_q  <= 1'b0;
      rd_prev_q  <= 1'b0;
      rd_defer_q <= 1'b0;
      dout_q     <= 8'h00;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      wr_prev_q  <= isa_write;
      rd_prev_q  <= isa_read;
      rd_defer_q <= (r_state_q == R_IDLE) && rd_req && wr_edge;
      dout_q     <= dout_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    push      = 1'b0;
    ovf_d     = ovf_q;
    case (w_state_q)
      W_IDLE: if (wr_edge) begin
        if (space) begin
          push      = 1'b1;
          w_state_d = W_DONE;
        end else begin
          w_state_d = W_PEND;
        end
      end
      W_PEND: if (!isa_write) begin
        ovf_d     = 1'b1;
        w_state_d = W_IDLE;
      end else if (space) begin
        push      = 1'b1;
        w_state_d = W_DONE;
      end
      W_DONE: if (!isa_write) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    dout_d    = dout_q;
    cnt_d     = cnt_q;
    case (r_state_q)
      R_IDLE: if (rd_req && !wr_edge) begin
        if (hit) begin
          dout_d    = hit_data;
          r_state_d = R_DONE;
        end else begin
          r_state_d = R_SLOT;
        end
      end
      R_SLOT: if (!isa_read) begin
        r_state_d = R_IDLE;
      end else if (isa_op_enable) begin
        cnt_d     = '0;
        r_state_d = R_LAT;
      end
      R_LAT: if (cnt_q == CW'(RD_LAT - 1)) begin
        dout_d    = vram.vram_dout;
        r_state_d = R_DONE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      R_DONE: if (!isa_read) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  assign bus_rdy   = (w_state_q != W_PEND) && (r_state_q != R_SLOT) && (r_state_q != R_LAT);
  assign isa_dout  = dout_q;
  assign overflow  = ovf_q;

  assign vram.vram_read  = read_slot;
  assign vram.vram_write = pop;
  assign vram.vram_addr  = read_slot ? isa_addr : (pop ? head.addr : '0);
  assign vram.vram_din   = pop ? head.data : 8'h00;

endmodule

// File: tb/tb_cga_isa_wbuf.sv
// Directed bench for cga_isa_wbuf: behavioural VRAM with RD_LAT read pipeline,
// write log for drain-order checks, hand-computed expectations.
module tb_cga_isa_wbuf;
  import cga_isa_wbuf_pkg::*;

  localparam int DEPTH  = 4;
  localparam int AW     = 19;
  localparam int RD_LAT = 2;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic [AW-1:0] isa_addr = '0;
  logic [7:0]    isa_din = '0;
  logic          isa_write = 1'b0;
  logic          isa_read = 1'b0;
  logic          isa_op_enable = 1'b0;
  logic [7:0]    isa_dout;
  logic          bus_rdy;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  cga_isa_wbuf_if #(.AW(AW)) vif ();

  cga_isa_wbuf #(.DEPTH(DEPTH), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .isa_addr      (isa_addr),
    .isa_din       (isa_din),
    .isa_write     (isa_write),
    .isa_read      (isa_read),
    .isa_op_enable (isa_op_enable),
    .isa_dout      (isa_dout),
    .bus_rdy       (bus_rdy),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .vram          (vif)
  );

  always #5 clk = ~clk;

  // VRAM model: read data appears RD_LAT (=2) cycles after the strobe cycle.
  logic [7:0]    vmem [4096];
  logic [7:0]    rd_p1;
  logic          pre_we = 1'b0;
  logic [11:0]   pre_a = '0;
  logic [7:0]    pre_d = '0;
  logic [AW-1:0] wlog_a [$];
  logic [7:0]    wlog_d [$];

  always @(posedge clk) begin
    if (pre_we) vmem[pre_a] <= pre_d;
    if (vif.vram_write) begin
      vmem[vif.vram_addr[11:0]] <= vif.vram_din;
      wlog_a.push_back(vif.vram_addr);
      wlog_d.push_back(vif.vram_din);
    end
    rd_p1         <= vif.vram_read ? vmem[vif.vram_addr[11:0]] : 8'h00;
    vif.vram_dout <= rd_p1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    isa_write = 1'b0;
    isa_read = 1'b0;
    isa_op_enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    wlog_a.delete();
    wlog_d.delete();
  endtask

  task automatic isa_wr(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    isa_addr = a;
    isa_din = d;
    isa_write = 1'b1;
    repeat (2) @(negedge clk);
    isa_write = 1'b0;
    @(negedge clk);
  endtask

  logic          s_wr, s_rd;
  logic [AW-1:0] s_addr;
  logic [7:0]    s_din;

  task automatic slot();
    @(negedge clk);
    isa_op_enable = 1'b1;
    #1;
    s_wr = vif.vram_write;
    s_rd = vif.vram_read;
    s_addr = vif.vram_addr;
    s_din = vif.vram_din;
    @(negedge clk);
    isa_op_enable = 1'b0;
  endtask

  task automatic check_log(input int idx, input logic [AW-1:0] a, input logic [7:0] d);
    if (idx < wlog_a.size()) begin
      check($sformatf("drain%0d_addr", idx), 32'(wlog_a[idx]), 32'(a));
      check($sformatf("drain%0d_data", idx), 32'(wlog_d[idx]), 32'(d));
    end else begin
      check($sformatf("drain%0d_present", idx), 32'(wlog_a.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int n;
    logic rdy_low;

    // 1: reset / idle
    do_reset();
    check("rst_bus_rdy", 32'(bus_rdy), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_vram_write", 32'(vif.vram_write), 32'd0);
    check("rst_vram_read", 32'(vif.vram_read), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_dout", 32'(isa_dout), 32'd0);

    // 2: single posted write drained in a later slot
    isa_wr(19'h00123, 8'hA5);
    check("w1_level", 32'(fifo_level), 32'd1);
    repeat (10) @(negedge clk);
    check("w1_no_early_drain", 32'(wlog_a.size()), 32'd0);
    slot();
    check("w1_strobe", 32'(s_wr), 32'd1);
    check("w1_addr", 32'(s_addr), 32'h00123);
    check("w1_data", 32'(s_din), 32'hA5);
    check("w1_level_after", 32'(fifo_level), 32'd0);

    // 3: full FIFO stalls 5th write; slot frees a place; drain order preserved
    do_reset();
    for (int i = 0; i < 4; i++) isa_wr(19'h00100 + 19'(i), 8'hC0 + 8'(i));
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_rdy_before", 32'(bus_rdy), 32'd1);
    @(negedge clk);
    isa_addr = 19'h00104;
    isa_din = 8'hC4;
    isa_write = 1'b1;
    @(negedge clk);
    check("stall_rdy", 32'(bus_rdy), 32'd0);
    repeat (2) @(negedge clk);
    check("stall_rdy_held", 32'(bus_rdy), 32'd0);
    slot();
    check("stall_pop_addr", 32'(s_addr), 32'h00100);
    check("stall_rdy_after", 32'(bus_rdy), 32'd1);
    check("stall_level_after", 32'(fifo_level), 32'd4);
    isa_write = 1'b0;
    @(negedge clk);
    repeat (4) slot();
    check("drain_level", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 5; i++) check_log(i, 19'h00100 + 19'(i), 8'hC0 + 8'(i));

    // 4: read hit forwards newest matching entry with no wait state
    do_reset();
    isa_wr(19'h00040, 8'h11);
    isa_wr(19'h00040, 8'h22);
    @(negedge clk);
    isa_addr = 19'h00040;
    isa_read = 1'b1;
    rdy_low = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (!bus_rdy) rdy_low = 1'b1;
    end
    check("hit_dout", 32'(isa_dout), 32'h22);
    check("hit_no_wait", 32'(rdy_low), 32'd0);
    isa_read = 1'b0;
    @(negedge clk);
    check("hit_level", 32'(fifo_level), 32'd2);
    check("hit_dout_held", 32'(isa_dout), 32'h22);

    // 5: read miss takes the first slot ahead of queued writes
    do_reset();
    @(negedge clk);
    pre_we = 1'b1;
    pre_a = 12'h200;
    pre_d = 8'h5A;
    @(negedge clk);
    pre_we = 1'b0;
    isa_wr(19'h00300, 8'h33);
    isa_wr(19'h00301, 8'h44);
    @(negedge clk);
    isa_addr = 19'h00200;
    isa_read = 1'b1;
    @(negedge clk);
    check("miss_rdy", 32'(bus_rdy), 32'd0);
    slot();
    check("miss_vram_read", 32'(s_rd), 32'd1);
    check("miss_no_write", 32'(s_wr), 32'd0);
    check("miss_addr", 32'(s_addr), 32'h00200);
    n = 0;
    while (!bus_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("miss_latency", 32'(n), 32'd2);
    check("miss_dout", 32'(isa_dout), 32'h5A);
    check("miss_writes_queued", 32'(fifo_level), 32'd2);
    isa_read = 1'b0;
    @(negedge clk);
    repeat (2) slot();
    check_log(0, 19'h00300, 8'h33);
    check_log(1, 19'h00301, 8'h44);

    // 7: read aborted in R_SLOT leaves the slot to the drain
    do_reset();
    isa_wr(19'h00020, 8'h77);
    @(negedge clk);
    isa_addr = 19'h00999;
    isa_read = 1'b1;
    @(negedge clk);
    check("abort_rdy_low", 32'(bus_rdy), 32'd0);
    isa_read = 1'b0;
    @(negedge clk);
    check("abort_rdy_back", 32'(bus_rdy), 32'd1);
    slot();
    check("abort_no_read", 32'(s_rd), 32'd0);
    check("abort_drain_addr", 32'(s_addr), 32'h00020);

    // 6: lost write sets overflow; reset mid-R_LAT clears everything
    do_reset();
    for (int i = 0; i < 4; i++) isa_wr(19'h00010 + 19'(i), 8'h50 + 8'(i));
    @(negedge clk);
    isa_addr = 19'h00014;
    isa_din = 8'h54;
    isa_write = 1'b1;
    repeat (2) @(negedge clk);
    check("ovf_stall", 32'(bus_rdy), 32'd0);
    isa_write = 1'b0;
    @(negedge clk);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_rdy", 32'(bus_rdy), 32'd1);
    @(negedge clk);
    isa_addr = 19'h00555;
    isa_read = 1'b1;
    @(negedge clk);
    slot();
    check("rlat_read_taken", 32'(s_rd), 32'd1);
    rst_l = 1'b0;
    #1;
    check("arst_rdy", 32'(bus_rdy), 32'd1);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_dout", 32'(isa_dout), 32'd0);
    check("arst_vram_read", 32'(vif.vram_read), 32'd0);
    isa_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_dout", 32'(isa_dout), 32'd0);
    check("post_rst_level", 32'(fifo_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
